probe_mux_arbiter: RTL and testbench
====================================

PROBE_MUX_ARBITER -- requirements
Module: probe_mux_arbiter

Interface
REQ-001 Parameters SHALL be: MUX_LAT, default 2, cycles from mux_addr change to valid mux_data (legal 1..15); BURST_MAX, default 8, maximum consecutive locked grants to one requester (legal 1..15).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
REQ-003 Ports SHALL continue:
- req0  in  1  JTAG-side read request (level).
- addr0  in  8  JTAG-side probe select code.
- lock0  in  1  JTAG-side keeps ownership for the next request.
- gnt0  out  1  one-cycle accept pulse to JTAG side.
- rvalid0  out  1  one-cycle read-data-valid pulse to JTAG side.
REQ-004 Ports SHALL continue:
- req1  in  1  LCD-refresh read request (level).
- addr1  in  8  LCD-refresh probe select code.
- lock1  in  1  LCD-refresh keeps ownership for the next request.
- gnt1  out  1  one-cycle accept pulse to LCD-refresh side.
- rvalid1  out  1  one-cycle read-data-valid pulse to LCD-refresh side.
REQ-005 Ports SHALL continue:
- rdata  out  8  read byte, shared by both requesters, qualified by rvalid0/rvalid1.
- mux_addr  out  8  select code driven to the shared probe mux.
- mux_data  in  8  byte returned by the shared probe mux.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-006 FSM SHALL have the states IDLE, BUSY and DONE, encoded in a registered state variable.
REQ-007 In IDLE, if any req is high, the next state SHALL be BUSY, with the winner chosen as in REQ-011..REQ-013; otherwise the FSM SHALL stay in IDLE.
REQ-008 On entering BUSY, the block SHALL:
- assert the winner's gnt for exactly that first BUSY cycle;
- register the winner's addr into mux_addr;
- clear the latency counter.
REQ-009 BUSY SHALL last exactly MUX_LAT cycles, with mux_addr held constant; at the clock edge ending the last BUSY cycle, the block SHALL register rdata <= mux_data and move to DONE.
REQ-010 DONE SHALL last one cycle, assert the owner's rvalid and go to IDLE; a req sampled high in IDLE SHALL reach rvalid in cycle t+MUX_LAT+1 (t = IDLE sample cycle).
REQ-011 Arbitration SHALL be round-robin: a last_owner register updates at each grant, and the non-last owner wins when both reqs are high; after reset last_owner=1, so requester 0 wins the first contention.
REQ-012 Lock: if the owner's lock was high in its DONE cycle and its req is high in the following IDLE cycle, the owner SHALL be re-granted regardless of the other req, while burst_cnt < BURST_MAX.
REQ-013 burst_cnt SHALL:
- be set to 1 on a non-lock grant;
- increment on each locked re-grant;
- when it reaches BURST_MAX with the other req high, force the grant to the other requester.
If the other req is low, the lock SHALL continue with burst_cnt saturated.
REQ-014 req, addr and lock SHALL be sampled only in IDLE; changes during BUSY/DONE SHALL be ignored, and a req still high in the next IDLE counts as a new request.
REQ-015 gnt0&gnt1 and rvalid0&rvalid1 SHALL never be high together; at most one transaction SHALL be outstanding.
REQ-016 rdata SHALL hold its value until the next DONE; mux_addr SHALL hold its value until the next grant.
REQ-017 An out-of-range parameter SHALL be rejected at elaboration.

Reset
REQ-018 While reset is high at a clock edge, the block SHALL set:
- state=IDLE, last_owner=1, burst_cnt=0, latency counter=0;
- mux_addr=0x00, rdata=0x00;
- gnt0=gnt1=rvalid0=rvalid1=busy=0.
REQ-019 Reset asserted in BUSY or DONE SHALL abort the transaction: no rvalid is emitted for it, and the first post-reset grant SHALL follow REQ-011.
REQ-020 No output SHALL change on the reset edge other than to its reset value.

Verification
REQ-021 Single read: MUX_LAT=2, req0=1, addr0=0x23, mux_data=0xA5 when mux_addr=0x23 -> gnt0 at t+1, rvalid0 at t+3, rdata=0xA5, rvalid1 never high.
REQ-022 Contention: req0 and req1 held high, lock=0 -> grant order 0,1,0,1; mux_addr alternates addr0/addr1; one rvalid per MUX_LAT+2 cycles.
REQ-023 Locked burst: lock1=1 with req1 and req0 held high, BURST_MAX=8, addr1 stepping 0x30..0x37 -> eight consecutive gnt1, then gnt0; same run with req0=0 -> gnt1 continues beyond eight.
REQ-024 Mid-transaction reset: reset pulsed in the second BUSY cycle of a req1 read -> no rvalid1, outputs at reset values; with both reqs high after reset, the next grant goes to requester 0.
REQ-025 Input churn: addr0 changed from 0x10 to 0x2F during BUSY -> mux_addr stays 0x10 and rdata is the 0x10 probe byte.

Source files
------------

// File: rtl/probe_mux_arbiter.sv
// Two-requester arbiter for a shared probe mux with a fixed read latency.
// Round-robin between the JTAG side (0) and the LCD-refresh side (1),
// with an optional locked burst capped at BURST_MAX consecutive grants.
module probe_mux_arbiter #(
  parameter int unsigned MUX_LAT   = 2,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic       lock0,
  output logic       gnt0,
  output logic       rvalid0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic       lock1,
  output logic       gnt1,
  output logic       rvalid1,
  output logic [7:0] rdata,
  output logic [7:0] mux_addr,
  input  logic [7:0] mux_data,
  output logic       busy
);

  localparam int unsigned CW = 4;

  // Reject parameters outside the 4-bit counter range at elaboration.
  if (MUX_LAT < 1 || MUX_LAT > 15) begin : g_bad_mux_lat
    $error("probe_mux_arbiter: MUX_LAT must be 1..15");
  end
  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("probe_mux_arbiter: BURST_MAX must be 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          owner_q, owner_d;
  logic          lock_q, lock_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    mux_addr_q, mux_addr_d;
  logic          busy_q, busy_d;

  logic          own_req, oth_req, relock, win;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    burst_d    = burst_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata_d    = rdata_q;
    mux_addr_d = mux_addr_q;
    own_req    = owner_q ? req1 : req0;
    oth_req    = owner_q ? req0 : req1;
    // Locked re-grant only in the IDLE cycle right after the owner's DONE.
    relock     = lock_q && own_req && ((burst_q < CW'(BURST_MAX)) || !oth_req);
    win        = owner_q;

    case (state_q)
      S_IDLE: begin
        lock_d = 1'b0;
        if (req0 || req1) begin
          if (relock) begin
            win = owner_q;
            if (burst_q < CW'(BURST_MAX)) begin
              burst_d = burst_q + CW'(1);
            end
          end else begin
            win     = (req0 && req1) ? ~owner_q : req1;
            burst_d = CW'(1);
          end
          owner_d    = win;
          gnt0_d     = ~win;
          gnt1_d     = win;
          mux_addr_d = win ? addr1 : addr0;
          lat_d      = '0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (lat_q == CW'(MUX_LAT - 1)) begin
          rdata_d   = mux_data;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
          state_d   = S_DONE;
        end else begin
          lat_d = lat_q + CW'(1);
        end
      end
      S_DONE: begin
        lock_d  = owner_q ? lock1 : lock0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      burst_q    <= '0;
      owner_q    <= 1'b1;
      lock_q     <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= 8'h00;
      mux_addr_q <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      burst_q    <= burst_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
      mux_addr_q <= mux_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign mux_addr = mux_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_probe_mux_arbiter.sv
// Bench for probe_mux_arbiter: transaction-scheduling reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_probe_mux_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned BM  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata, mux_addr, mux_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  probe_mux_arbiter #(.MUX_LAT(LAT), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mux_addr(mux_addr), .mux_data(mux_data), .busy(busy)
  );

  // Probe mux stand-in: each select code returns a fixed byte.
  assign mux_data = mux_addr ^ 8'h86;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log used by the directed checks.
  int         gw[$], gc[$], rw[$], rc[$];
  logic [7:0] ga[$], rd[$];
  int         n1 = 0;

  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      gw.push_back(gnt1 ? 1 : 0); gc.push_back(cyc); ga.push_back(mux_addr);
      if (gnt1) n1 = n1 + 1;
    end
    if (rvalid0 || rvalid1) begin
      rw.push_back(rvalid1 ? 1 : 0); rc.push_back(cyc); rd.push_back(rdata);
    end
  end

  // Reference model: on a grant decision in cycle c, schedule gnt at c+1,
  // rdata/rvalid at c+LAT+1 and the next free IDLE cycle at c+LAT+2.
  logic       mvalid = 1'b0;
  logic       e_g0, e_g1, e_r0, e_r1, e_busy;
  logic [7:0] e_rdata, e_mux;
  int         m_owner, m_burst, m_lockf, m_idle_at, m_rd_at, m_done_at, m_lockchk;

  always @(negedge clk) begin
    int c;
    int own_req, oth_req, win;
    c = cyc;
    if (mvalid) begin
      vectors = vectors + 1;
      if (gnt0 !== e_g0 || gnt1 !== e_g1 || rvalid0 !== e_r0 || rvalid1 !== e_r1 ||
          busy !== e_busy || rdata !== e_rdata || mux_addr !== e_mux) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle %0d outputs: got gnt=%b%b rv=%b%b busy=%b rdata=%h mux=%h, expected gnt=%b%b rv=%b%b busy=%b rdata=%h mux=%h",
                 c, gnt1, gnt0, rvalid1, rvalid0, busy, rdata, mux_addr,
                 e_g1, e_g0, e_r1, e_r0, e_busy, e_rdata, e_mux);
      end
    end
    if (reset) begin
      {e_g0, e_g1, e_r0, e_r1, e_busy} = '0;
      e_rdata = 8'h00; e_mux = 8'h00;
      m_owner = 1; m_burst = 0; m_lockf = 0;
      m_idle_at = c + 1; m_rd_at = -1; m_done_at = -1; m_lockchk = -1;
      mvalid = 1'b1;
    end else if (mvalid) begin
      {e_g0, e_g1, e_r0, e_r1} = '0;
      if (c == m_done_at) begin
        m_lockf = (m_owner == 1) ? int'(lock1) : int'(lock0);
        m_lockchk = c + 1;
      end
      if (c == m_rd_at) begin
        e_rdata = e_mux ^ 8'h86;
        if (m_owner == 1) e_r1 = 1'b1; else e_r0 = 1'b1;
      end
      if (c >= m_idle_at && (req0 || req1)) begin
        own_req = (m_owner == 1) ? int'(req1) : int'(req0);
        oth_req = (m_owner == 1) ? int'(req0) : int'(req1);
        if (m_lockf != 0 && c == m_lockchk && own_req != 0 &&
            (m_burst < int'(BM) || oth_req == 0)) begin
          win = m_owner;
          if (m_burst < int'(BM)) m_burst = m_burst + 1;
        end else begin
          win = (req0 && req1) ? 1 - m_owner : int'(req1);
          m_burst = 1;
        end
        m_owner = win;
        e_mux = (win == 1) ? addr1 : addr0;
        if (win == 1) e_g1 = 1'b1; else e_g0 = 1'b1;
        m_rd_at   = c + int'(LAT);
        m_done_at = c + int'(LAT) + 1;
        m_idle_at = c + int'(LAT) + 2;
      end
      e_busy = (c + 1 < m_idle_at);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    reset = 1; tick(2); reset = 0; tick(1);
  endtask

  task automatic clear_log();
    gw.delete(); gc.delete(); ga.delete(); rw.delete(); rc.delete(); rd.delete();
    n1 = 0;
  endtask

  initial begin
    int t, k, ones;
    tick(3);
    reset = 0; tick(1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mux_addr", int'(mux_addr), 0);

    // Single read of probe 0x23.
    do_reset(); clear_log();
    req0 = 1; addr0 = 8'h23; t = cyc;
    tick(1); req0 = 0;
    tick(LAT + 4);
    chk("single_gnt_count", gw.size(), 1);
    chk("single_rv_count", rw.size(), 1);
    if (gw.size() >= 1 && rw.size() >= 1) begin
      chk("single_gnt_who", gw[0], 0);
      chk("single_gnt_lat", gc[0] - t, 1);
      chk("single_rv_who", rw[0], 0);
      chk("single_rv_lat", rc[0] - t, 3);
      chk("single_rdata", int'(rd[0]), 8'hA5);
    end

    // Contention, no lock: strict alternation starting with requester 0.
    do_reset(); clear_log();
    addr0 = 8'h11; addr1 = 8'h22; req0 = 1; req1 = 1; t = cyc;
    tick(4 * (LAT + 2));
    req0 = 0; req1 = 0; tick(LAT + 3);
    chk("rr_grants", (gw.size() >= 4) ? 1 : 0, 1);
    if (gw.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_who", gw[i], i % 2);
        chk("rr_addr", int'(ga[i]), (i % 2 == 0) ? 8'h11 : 8'h22);
        chk("rr_spacing", gc[i] - t, 1 + i * int'(LAT + 2));
      end
    end

    // Locked burst by requester 1 against a contending requester 0.
    do_reset(); clear_log();
    req1 = 1; lock1 = 1; addr1 = 8'h30; addr0 = 8'h44;
    for (k = 0; k < 11 * int'(LAT + 2); k++) begin
      tick(1);
      addr1 = 8'h30 + 8'(n1);
      if (n1 >= 1) req0 = 1;
    end
    req0 = 0; req1 = 0; lock1 = 0; tick(LAT + 3);
    chk("burst_grants", (gw.size() >= 9) ? 1 : 0, 1);
    if (gw.size() >= 9) begin
      for (int i = 0; i < 8; i++) begin
        chk("burst_who", gw[i], 1);
        chk("burst_addr", int'(ga[i]), 8'h30 + i);
      end
      chk("burst_handover", gw[8], 0);
    end

    // Locked burst with no contention keeps going past BURST_MAX.
    do_reset(); clear_log();
    req1 = 1; lock1 = 1; addr1 = 8'h30;
    tick(13 * int'(LAT + 2));
    req1 = 0; lock1 = 0; tick(LAT + 3);
    ones = 0;
    foreach (gw[i]) if (gw[i] == 1) ones++;
    chk("burst_solo_all_one", ones, gw.size());
    chk("burst_solo_beyond", (gw.size() > int'(BM)) ? 1 : 0, 1);

    // Reset in the second BUSY cycle of a requester-1 read.
    do_reset(); clear_log();
    req1 = 1; addr1 = 8'h55;
    tick(1); req1 = 0;
    tick(1); reset = 1;
    tick(1); reset = 0;
    chk("abort_busy", int'(busy), 0);
    tick(LAT + 2);
    chk("abort_no_rvalid", rw.size(), 0);
    req0 = 1; req1 = 1; addr0 = 8'h66;
    tick(2); req0 = 0; req1 = 0;
    tick(LAT + 3);
    chk("abort_grants", gw.size(), 2);
    if (gw.size() >= 2) chk("abort_next_who", gw[1], 0);

    // Address churn during BUSY is ignored.
    do_reset(); clear_log();
    req0 = 1; addr0 = 8'h10;
    tick(1); req0 = 0; addr0 = 8'h2F;
    tick(LAT + 3);
    chk("churn_grants", gw.size(), 1);
    if (gw.size() >= 1 && rd.size() >= 1) begin
      chk("churn_mux", int'(ga[0]), 8'h10);
      chk("churn_rdata", int'(rd[0]), 8'h96);
    end
    chk("churn_mux_hold", int'(mux_addr), 8'h10);

    // Random traffic, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      req0  = ($urandom_range(0, 9) < 6);
      req1  = ($urandom_range(0, 9) < 6);
      lock0 = ($urandom_range(0, 9) < 5);
      lock1 = ($urandom_range(0, 9) < 7);
      addr0 = 8'($urandom);
      addr1 = 8'($urandom);
      reset = ($urandom_range(0, 249) == 0);
    end
    reset = 0; req0 = 0; req1 = 0; tick(LAT + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
